// File: rtl/calc_op_sequencer_if.sv
// ALU-side bundle of the calculator sequencer: latched operands, function code,
// start/done handshake and the signed result returned by the shared ALU.
interface calc_op_sequencer_if #(
    parameter int DATA_W = 4,
    parameter int RES_W  = 8
);
    logic [DATA_W-1:0] alu_a_out;
    logic [DATA_W-1:0] alu_b_out;
    logic [1:0]        alu_fn_out;
    logic              alu_start_out;
    logic              alu_done_in;
    logic [RES_W:0]    alu_result_in;

    modport master (
        output alu_a_out, alu_b_out, alu_fn_out, alu_start_out,
        input  alu_done_in, alu_result_in
    );

    modport slave (
        input  alu_a_out, alu_b_out, alu_fn_out, alu_start_out,
        output alu_done_in, alu_result_in
    );
endinterface

// File: rtl/calc_op_sequencer.sv
// Calculator op sequencer: operand capture, ALU start/done handshake and a serial
// double-dabble to packed BCD. Defining CALC_TIMEOUT_EN adds an ALU watchdog (TO_CYC).
module calc_op_sequencer #(
    parameter int DATA_W = 4,
    parameter int RES_W  = 8,
    parameter int DIGITS = 3
`ifdef CALC_TIMEOUT_EN
    ,
    parameter int TO_CYC = 255
`endif
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_W-1:0]    dat_in,
    input  logic [1:0]           function_in,
    input  logic                 enter_in,
    input  logic                 clear_in,
    calc_op_sequencer_if.master  alu,
    output logic [4*DIGITS-1:0]  bcd_out,
    output logic                 neg_out,
    output logic                 err_out,
    output logic                 valid_out,
    output logic                 busy_out
);
    localparam int                  CNT_W   = $clog2(RES_W + 1);
    localparam logic [31:0]         BCD_MAX = 32'(10 ** DIGITS - 1);
    localparam logic [4*DIGITS-1:0] ALL_F   = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_B,
        S_EXEC,
        S_CONV,
        S_SHOW
    } state_t;

    state_t              r_state;
    state_t              w_state_next;

    logic [DATA_W-1:0]   r_a;
    logic [DATA_W-1:0]   r_b;
    logic [1:0]          r_fn;
    logic                r_first;
    logic [RES_W-1:0]    r_shift;
    logic [4*DIGITS-1:0] r_work;
    logic [4*DIGITS-1:0] r_bcd;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_ovf;
    logic                r_neg;
    logic                r_err;
    logic                r_valid;

    logic                w_div0;
    logic                w_done_ok;
    logic                w_conv_last;
    logic                w_timeout;
    logic                w_start;
    logic                w_busy;
    logic [RES_W-1:0]    w_mag;
    logic                w_res_neg;
    logic                w_ovf;
    logic [4*DIGITS-1:0] w_adj;
    logic [4*DIGITS-1:0] w_work_next;

    assign w_div0      = (function_in == 2'b11) && (dat_in == '0);
    // A done coinciding with the start pulse belongs to no operation of ours.
    assign w_done_ok   = (r_state == S_EXEC) && !r_first && alu.alu_done_in;
    assign w_conv_last = (r_state == S_CONV) && (r_cnt == CNT_W'(RES_W - 1));

    assign w_mag     = alu.alu_result_in[RES_W] ? (~alu.alu_result_in[RES_W-1:0] + 1'b1)
                                                : alu.alu_result_in[RES_W-1:0];
    assign w_res_neg = alu.alu_result_in[RES_W] && (w_mag != '0);
    assign w_ovf     = 32'(w_mag) > BCD_MAX;

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_add3
            assign w_adj[4*gi +: 4] = (r_work[4*gi +: 4] >= 4'd5) ? (r_work[4*gi +: 4] + 4'd3)
                                                                  : r_work[4*gi +: 4];
        end
    endgenerate
    assign w_work_next = (w_adj << 1) | (4*DIGITS)'(r_shift[RES_W-1]);

`ifdef CALC_TIMEOUT_EN
    localparam int TO_W = $clog2(TO_CYC + 1);
    logic [TO_W-1:0] r_to;

    // Counts cycles since the start pulse; the start cycle itself is count 0.
    assign w_timeout = (r_state == S_EXEC) && !w_done_ok && (r_to == TO_W'(TO_CYC - 1));

    always_ff @(posedge clk) begin
        if (rst || clear_in || (r_state != S_EXEC)) begin
            r_to <= '0;
        end else begin
            r_to <= r_to + 1'b1;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst || clear_in) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   if (enter_in) w_state_next = S_WAIT_B;
            S_WAIT_B: if (enter_in) w_state_next = w_div0 ? S_SHOW : S_EXEC;
            S_EXEC: begin
                if (w_done_ok) begin
                    w_state_next = S_CONV;
                end else if (w_timeout) begin
                    w_state_next = S_SHOW;
                end
            end
            S_CONV:   if (w_conv_last) w_state_next = S_SHOW;
            S_SHOW:   if (enter_in) w_state_next = S_WAIT_B;
            default:  w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_start = 1'b0;
        w_busy  = 1'b0;
        case (r_state)
            S_EXEC: begin
                w_start = r_first;
                w_busy  = 1'b1;
            end
            S_CONV:  w_busy = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || clear_in) begin
            r_a     <= '0;
            r_b     <= '0;
            r_fn    <= '0;
            r_first <= 1'b0;
            r_shift <= '0;
            r_work  <= '0;
            r_bcd   <= '0;
            r_cnt   <= '0;
            r_ovf   <= 1'b0;
            r_neg   <= 1'b0;
            r_err   <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_SHOW: begin
                    if (enter_in) begin
                        r_a     <= dat_in;
                        r_valid <= 1'b0;
                    end
                end
                S_WAIT_B: begin
                    if (enter_in) begin
                        r_b  <= dat_in;
                        r_fn <= function_in;
                        if (w_div0) begin
                            r_err   <= 1'b1;
                            r_neg   <= 1'b0;
                            r_bcd   <= ALL_F;
                            r_valid <= 1'b1;
                        end else begin
                            r_first <= 1'b1;
                        end
                    end
                end
                S_EXEC: begin
                    r_first <= 1'b0;
                    if (w_done_ok) begin
                        r_neg   <= w_res_neg;
                        r_shift <= w_mag;
                        r_ovf   <= w_ovf;
                        r_work  <= '0;
                        r_cnt   <= '0;
                    end else if (w_timeout) begin
                        r_err   <= 1'b1;
                        r_neg   <= 1'b0;
                        r_bcd   <= ALL_F;
                        r_valid <= 1'b1;
                    end
                end
                S_CONV: begin
                    r_shift <= r_shift << 1;
                    r_work  <= w_work_next;
                    r_cnt   <= r_cnt + 1'b1;
                    if (w_conv_last) begin
                        r_bcd   <= r_ovf ? ALL_F : w_work_next;
                        r_err   <= r_ovf;
                        r_valid <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign alu.alu_a_out     = r_a;
    assign alu.alu_b_out     = r_b;
    assign alu.alu_fn_out    = r_fn;
    assign alu.alu_start_out = w_start;
    assign bcd_out           = r_bcd;
    assign neg_out           = r_neg;
    assign err_out           = r_err;
    assign valid_out         = r_valid;
    assign busy_out          = w_busy;
endmodule

// File: tb/tb_calc_op_sequencer.sv
// Randomised self-checking bench for calc_op_sequencer; the ALU is modelled with
// plain integer arithmetic and BCD expectations come from decimal digit extraction.
module tb_calc_op_sequencer;
    localparam int DATA_W = 4;
    localparam int RES_W  = 8;
    localparam int DIGITS = 3;
    localparam int TO_CYC = 255;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [DATA_W-1:0] dat_in = '0;
    logic [1:0]        function_in = '0;
    logic              enter_in = 1'b0;
    logic              clear_in = 1'b0;
    logic [11:0]       bcd_out;
    logic              neg_out;
    logic              err_out;
    logic              valid_out;
    logic              busy_out;
    logic [26:0]       all_outs;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    calc_op_sequencer_if #(.DATA_W(DATA_W), .RES_W(RES_W)) alu_bus ();

    calc_op_sequencer #(.DATA_W(DATA_W), .RES_W(RES_W), .DIGITS(DIGITS)) dut (
        .clk         (clk),
        .rst         (rst),
        .dat_in      (dat_in),
        .function_in (function_in),
        .enter_in    (enter_in),
        .clear_in    (clear_in),
        .alu         (alu_bus),
        .bcd_out     (bcd_out),
        .neg_out     (neg_out),
        .err_out     (err_out),
        .valid_out   (valid_out),
        .busy_out    (busy_out)
    );

    assign all_outs = {alu_bus.alu_a_out, alu_bus.alu_b_out, alu_bus.alu_fn_out,
                       alu_bus.alu_start_out, bcd_out, neg_out, err_out, valid_out, busy_out};

    function automatic int ref_alu(int a, int b, int fn);
        case (fn)
            0:       return a + b;
            1:       return a - b;
            2:       return a * b;
            default: return (b == 0) ? 0 : a / b;
        endcase
    endfunction

    function automatic logic [11:0] ref_bcd(int mag);
        if (mag > 999) return 12'hFFF;
        return {4'((mag / 100) % 10), 4'((mag / 10) % 10), 4'(mag % 10)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full operation from first enter to the displayed result.
    task automatic run_op(input int a, input int b, input int fn, input int delay,
                          input bit noise, input string tag);
        int r;
        int mag;
        logic [11:0] exp_bcd;
        logic        exp_neg;
        dat_in = 4'(a); function_in = 2'($urandom); enter_in = 1'b1;
        tick();
        enter_in = 1'b0;
        n_cmp++;
        if (valid_out !== 1'b0 || busy_out !== 1'b0 || alu_bus.alu_a_out !== 4'(a)) begin
            n_bad++;
            $display("FAIL %s first_enter: valid=%0b busy=%0b a=%0d, want 0 0 %0d",
                     tag, valid_out, busy_out, alu_bus.alu_a_out, a);
        end
        dat_in = 4'(b); function_in = 2'(fn); enter_in = 1'b1;
        tick();
        enter_in = 1'b0; dat_in = 4'($urandom); function_in = 2'($urandom);
        if (fn == 3 && b == 0) begin
            n_cmp++;
            if ({alu_bus.alu_start_out, err_out, valid_out, neg_out, busy_out, bcd_out}
                !== {5'b01100, 12'hFFF}) begin
                n_bad++;
                $display("FAIL %s div0: start=%0b err=%0b valid=%0b neg=%0b busy=%0b bcd=%h, want 0 1 1 0 0 fff",
                         tag, alu_bus.alu_start_out, err_out, valid_out, neg_out, busy_out, bcd_out);
            end
            tick();
            n_cmp++;
            if (alu_bus.alu_start_out !== 1'b0 || valid_out !== 1'b1) begin
                n_bad++;
                $display("FAIL %s div0_hold: start=%0b valid=%0b, want 0 1", tag,
                         alu_bus.alu_start_out, valid_out);
            end
            return;
        end
        n_cmp++;
        if (alu_bus.alu_start_out !== 1'b1 || alu_bus.alu_a_out !== 4'(a) ||
            alu_bus.alu_b_out !== 4'(b) || alu_bus.alu_fn_out !== 2'(fn)) begin
            n_bad++;
            $display("FAIL %s start: start=%0b a=%0d b=%0d fn=%0d, want 1 %0d %0d %0d", tag,
                     alu_bus.alu_start_out, alu_bus.alu_a_out, alu_bus.alu_b_out,
                     alu_bus.alu_fn_out, a, b, fn);
        end
        r       = ref_alu(a, b, fn);
        mag     = (r < 0) ? -r : r;
        exp_neg = (r < 0);
        exp_bcd = ref_bcd(mag);
        if (noise) begin
            alu_bus.alu_done_in   = 1'b1;
            alu_bus.alu_result_in = 9'($urandom);
        end
        for (int i = 0; i < delay; i++) begin
            tick();
            alu_bus.alu_done_in = 1'b0;
            enter_in = noise && (i == 0);
            dat_in   = 4'($urandom);
            n_cmp++;
            if (alu_bus.alu_start_out !== 1'b0 || busy_out !== 1'b1 ||
                alu_bus.alu_a_out !== 4'(a) || alu_bus.alu_b_out !== 4'(b)) begin
                n_bad++;
                $display("FAIL %s exec_hold: start=%0b busy=%0b a=%0d b=%0d, want 0 1 %0d %0d",
                         tag, alu_bus.alu_start_out, busy_out, alu_bus.alu_a_out,
                         alu_bus.alu_b_out, a, b);
            end
        end
        enter_in = 1'b0;
        alu_bus.alu_done_in   = 1'b1;
        alu_bus.alu_result_in = 9'(r);
        tick();
        alu_bus.alu_done_in   = 1'b0;
        alu_bus.alu_result_in = 9'($urandom);
        for (int k = 0; k < RES_W; k++) begin
            n_cmp++;
            if (valid_out !== 1'b0 || busy_out !== 1'b1) begin
                n_bad++;
                $display("FAIL %s conv_wait[%0d]: valid=%0b busy=%0b, want 0 1", tag, k,
                         valid_out, busy_out);
            end
            tick();
        end
        n_cmp++;
        if ({valid_out, busy_out, err_out, neg_out, bcd_out} !== {3'b100, exp_neg, exp_bcd}) begin
            n_bad++;
            $display("FAIL %s result: valid=%0b busy=%0b err=%0b neg=%0b bcd=%h, want 1 0 0 %0b %h",
                     tag, valid_out, busy_out, err_out, neg_out, bcd_out, exp_neg, exp_bcd);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_cmp++;
            if (all_outs !== 27'd0) begin
                n_bad++;
                $display("FAIL reset_idle[%0d]: outputs=%h, want 0", i, all_outs);
            end
        end
    endtask

    task automatic test_fixed_ops();
        run_op(7, 9, 0, 3, 1'b0, "add_7_9");
        run_op(3, 12, 1, 3, 1'b0, "sub_3_12");
        run_op(5, 5, 1, 2, 1'b0, "sub_zero");
        run_op(0, 15, 1, 1, 1'b0, "sub_min");
        run_op(5, 0, 3, 3, 1'b0, "div_zero");
        run_op(9, 3, 3, 4, 1'b1, "done_on_start");
        run_op(15, 15, 2, 3, 1'b0, "mul_max");
    endtask

    task automatic test_reenter();
        dat_in = 4'd2; enter_in = 1'b1;
        tick();
        enter_in = 1'b0;
        n_cmp++;
        if (valid_out !== 1'b0 || busy_out !== 1'b0 || alu_bus.alu_a_out !== 4'd2) begin
            n_bad++;
            $display("FAIL reenter: valid=%0b busy=%0b a=%0d, want 0 0 2", valid_out, busy_out,
                     alu_bus.alu_a_out);
        end
        clear_in = 1'b1;
        tick();
        clear_in = 1'b0;
        n_cmp++;
        if (all_outs !== 27'd0) begin
            n_bad++;
            $display("FAIL clear_wait_b: outputs=%h, want 0", all_outs);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 24; n++) begin
            run_op(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                   int'($urandom_range(0, 3)), int'($urandom_range(1, 6)),
                   1'($urandom_range(0, 1)), $sformatf("rand%0d", n));
        end
    endtask

    task automatic test_clear_conv();
        dat_in = 4'd6; enter_in = 1'b1;
        tick();
        dat_in = 4'd7; function_in = 2'd2;
        tick();
        enter_in = 1'b0;
        tick();
        alu_bus.alu_done_in = 1'b1; alu_bus.alu_result_in = 9'd42;
        tick();
        alu_bus.alu_done_in = 1'b0;
        repeat (2) tick();
        clear_in = 1'b1; enter_in = 1'b1; dat_in = 4'd9;
        tick();
        clear_in = 1'b0; enter_in = 1'b0;
        n_cmp++;
        if (all_outs !== 27'd0) begin
            n_bad++;
            $display("FAIL clear_conv: outputs=%h, want 0", all_outs);
        end
        alu_bus.alu_done_in = 1'b1;
        tick();
        alu_bus.alu_done_in = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            n_cmp++;
            if (all_outs !== 27'd0) begin
                n_bad++;
                $display("FAIL late_done_conv[%0d]: outputs=%h, want 0", i, all_outs);
            end
        end
    endtask

    task automatic test_clear_exec();
        dat_in = 4'd4; enter_in = 1'b1;
        tick();
        dat_in = 4'd3; function_in = 2'd0;
        tick();
        enter_in = 1'b0;
        tick();
        clear_in = 1'b1;
        tick();
        clear_in = 1'b0;
        n_cmp++;
        if (all_outs !== 27'd0) begin
            n_bad++;
            $display("FAIL clear_exec: outputs=%h, want 0", all_outs);
        end
        tick();
        alu_bus.alu_done_in = 1'b1; alu_bus.alu_result_in = 9'd7;
        tick();
        alu_bus.alu_done_in = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            n_cmp++;
            if (valid_out !== 1'b0 || busy_out !== 1'b0 || bcd_out !== 12'h000) begin
                n_bad++;
                $display("FAIL late_done_exec[%0d]: valid=%0b busy=%0b bcd=%h, want 0 0 000", i,
                         valid_out, busy_out, bcd_out);
            end
        end
        run_op(2, 3, 0, 1, 1'b0, "after_clear");
    endtask

    task automatic test_rst_mid();
        dat_in = 4'd8; enter_in = 1'b1;
        tick();
        dat_in = 4'd2; function_in = 2'd1;
        tick();
        enter_in = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++;
        if (all_outs !== 27'd0) begin
            n_bad++;
            $display("FAIL rst_mid: outputs=%h, want 0", all_outs);
        end
    endtask

`ifdef CALC_TIMEOUT_EN
    task automatic test_timeout();
        dat_in = 4'd4; enter_in = 1'b1;
        tick();
        function_in = 2'd0;
        tick();
        enter_in = 1'b0;
        for (int k = 1; k <= TO_CYC; k++) begin
            tick();
            if (k == TO_CYC - 1) begin
                n_cmp++;
                if (err_out !== 1'b0 || valid_out !== 1'b0 || busy_out !== 1'b1) begin
                    n_bad++;
                    $display("FAIL timeout_early: err=%0b valid=%0b busy=%0b, want 0 0 1",
                             err_out, valid_out, busy_out);
                end
            end
        end
        n_cmp++;
        if ({err_out, valid_out, busy_out, neg_out, bcd_out} !== {4'b1100, 12'hFFF}) begin
            n_bad++;
            $display("FAIL timeout: err=%0b valid=%0b busy=%0b neg=%0b bcd=%h, want 1 1 0 0 fff",
                     err_out, valid_out, busy_out, neg_out, bcd_out);
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, compared=%0d", n_cmp);
        $fatal(1, "time limit");
    end

    initial begin
        alu_bus.alu_done_in   = 1'b0;
        alu_bus.alu_result_in = '0;
        test_reset();
        test_fixed_ops();
        test_reenter();
        test_random();
        test_clear_conv();
        test_clear_exec();
        test_rst_mid();
`ifdef CALC_TIMEOUT_EN
        test_timeout();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/calc_op_sequencer.md
Name: calc_op_sequencer

Overview:
Sequential front-end controller for the calculator datapath. Captures operand A, operand B and the function code from switches on successive enter strobes, then issues one operation to the shared ALU over a start/done handshake. It converts the signed ALU result to packed BCD with an iterative double-dabble, one bit per cycle. It then holds the digits, sign and error flags for the seven-segment decoders.

Parameters:
DATA_W, 4, operand width
RES_W, 8, result magnitude width; also the number of conversion cycles
DIGITS, 3, number of BCD digits produced
TO_CYC, 255, ALU watchdog limit in cycles (used only with the optional feature)

Ports:
clk  in  1  system clock; all state changes on its rising edge
rst  in  1  synchronous, active-high reset
dat_in  in  DATA_W  operand switches
function_in  in  2  operation code: 00 add, 01 sub, 10 mul, 11 div
enter_in  in  1  debounced single-cycle enter strobe
clear_in  in  1  debounced single-cycle clear strobe
alu_a_out  out  DATA_W  latched operand A to the ALU
alu_b_out  out  DATA_W  latched operand B to the ALU
alu_fn_out  out  2  latched function code to the ALU
alu_start_out  out  1  one-cycle start pulse
alu_done_in  in  1  one-cycle ALU completion pulse
alu_result_in  in  RES_W+1  two's-complement ALU result, valid while alu_done_in=1
bcd_out  out  4*DIGITS  packed BCD; bits [3:0] are the ones digit
neg_out  out  1  result is negative
err_out  out  1  divide-by-zero, overflow or timeout
valid_out  out  1  bcd_out, neg_out and err_out are valid
busy_out  out  1  high in S_EXEC and S_CONV

Behaviour:
- Reset: state=S_IDLE; every output and internal register is 0.
- States and transitions:
  - S_IDLE: on enter, latch A=dat_in, clear valid_out, go to S_WAIT_B.
  - S_WAIT_B: on enter, latch B=dat_in and fn=function_in. If fn=11 and dat_in=0, go to S_SHOW with err_out=1, bcd_out all 4'hF, neg_out=0, and no ALU start. Otherwise go to S_EXEC.
  - S_EXEC: alu_start_out=1 for exactly the first cycle in the state. alu_a/b/fn_out are stable from entry until S_CONV is left. On alu_done_in, capture the result: neg = result MSB; magnitude = |result|, RES_W bits. Go to S_CONV.
  - S_CONV: double-dabble runs RES_W cycles (add 3 to every digit >=5, then shift one bit). After the last shift, go to S_SHOW. If the magnitude is greater than 10^DIGITS-1, set err_out=1 and bcd_out all 4'hF instead of the converted value.
  - S_SHOW: valid_out=1 and all outputs held. On enter, latch a new A, drop valid_out, go to S_WAIT_B.
- Latency: alu_start_out rises the cycle after the second enter. valid_out rises exactly RES_W+1 cycles after the alu_done_in cycle.
- enter_in is ignored in S_EXEC and S_CONV.
- alu_done_in is ignored outside S_EXEC, including when it arrives in the same cycle as the start pulse.
- clear_in has priority over enter_in in every state: next cycle state=S_IDLE and all outputs 0, same as reset. Clear during S_EXEC abandons the operation; a later done is ignored.
- rst asserted mid-operation behaves identically to clear.
- The subtract result -0 cannot occur (magnitude 0 forces neg_out=0).

Optional Feature:
CALC_TIMEOUT_EN
- Defined: a counter runs in S_EXEC. If no alu_done_in arrives within TO_CYC cycles of the start pulse, go to S_SHOW with err_out=1 and bcd_out all 4'hF.
- Undefined: no counter; S_EXEC waits indefinitely for done.

Test Plan:
- Reset, then idle 10 cycles -> all outputs 0, busy_out=0, no start pulse.
- A=7, B=9, fn=00; ALU model returns 16 three cycles after start -> single start pulse with a=7, b=9, fn=00; 9 cycles after done: bcd_out=12'h016, neg_out=0, err_out=0, valid_out=1.
- A=3, B=12, fn=01; ALU model returns -9 -> bcd_out=12'h009, neg_out=1, valid_out=1.
- A=15, B=15, fn=10; ALU model returns 225 -> bcd_out=12'h225. A further enter with dat_in=2 -> valid_out=0 next cycle, state=S_WAIT_B.
- A=5, B=0, fn=11 -> no alu_start_out; next cycle err_out=1, bcd_out=12'hFFF, valid_out=1.
- clear_in and enter_in asserted together during S_CONV -> S_IDLE next cycle, outputs 0; a late alu_done_in is ignored. With CALC_TIMEOUT_EN defined and done withheld, err_out=1 exactly TO_CYC cycles after start.
